// File: rtl/axis_arb_pkg.sv
// rtl/axis_arb_pkg.sv - shared types and round-robin helper for the AXI-Stream arbiters
package axis_arb_pkg;

  localparam int MAX_INPUTS = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PASS = 1'b1
  } state_e;

  // Walk from the farthest candidate back to last+1 so the nearest requester wins.
  function automatic int rr_next(input logic [MAX_INPUTS-1:0] req, input int last, input int n);
    int sel;
    int k;
    sel = last;
    for (int i = MAX_INPUTS; i >= 1; i--) begin
      k = last + i;
      if (k >= n) k = k - n;
      if (i <= n && req[k[3:0]]) sel = k;
    end
    return sel;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant selection
module rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int IDX_W      = $clog2(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] req_i,
  input  logic [IDX_W-1:0]      last_grant_i,
  output logic [IDX_W-1:0]      grant_idx_o,
  output logic                  any_req_o
);

  logic [MAX_INPUTS-1:0] req_ext;

  always_comb begin
    req_ext = '0;
    req_ext[NUM_INPUTS-1:0] = req_i;
  end

  assign grant_idx_o = IDX_W'(rr_next(req_ext, int'(last_grant_i), NUM_INPUTS));
  assign any_req_o   = |req_i;

endmodule

// File: rtl/axis_arb_mux.sv
// rtl/axis_arb_mux.sv - packet-granular round-robin merge of AXI-Stream sources
module axis_arb_mux
  import axis_arb_pkg::*;
#(
  parameter int NUM_INPUTS     = 4,
  parameter int AXIS_BYTES     = 1,
  parameter int AXIS_USER_BITS = 1
) (
  input  logic                          clk,
  input  logic                          sreset,
  input  logic [NUM_INPUTS-1:0]         axis_i_tvalid,
  output logic [NUM_INPUTS-1:0]         axis_i_tready,
  input  logic [8*AXIS_BYTES-1:0]       axis_i_tdata [NUM_INPUTS],
  input  logic [AXIS_USER_BITS-1:0]     axis_i_tuser [NUM_INPUTS],
  input  logic [NUM_INPUTS-1:0]         axis_i_tlast,
  output logic                          axis_o_tvalid,
  input  logic                          axis_o_tready,
  output logic [8*AXIS_BYTES-1:0]       axis_o_tdata,
  output logic [AXIS_USER_BITS-1:0]     axis_o_tuser,
  output logic                          axis_o_tlast,
  output logic                          grant_active,
  output logic [$clog2(NUM_INPUTS)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(NUM_INPUTS);
  localparam int DW    = 8 * AXIS_BYTES;

  state_e                    state_q;
  logic [IDX_W-1:0]          grant_idx_q;
  logic [IDX_W-1:0]          last_grant_q;
  logic                      grant_active_q;
  logic                      out_valid_q;
  logic [DW-1:0]             out_data_q;
  logic [AXIS_USER_BITS-1:0] out_user_q;
  logic                      out_last_q;

  logic [IDX_W-1:0] arb_idx;
  logic             any_req;
  logic             in_ready;
  logic             accept;

  rr_arbiter #(
    .NUM_INPUTS (NUM_INPUTS),
    .IDX_W      (IDX_W)
  ) u_rr_arbiter (
    .req_i        (axis_i_tvalid),
    .last_grant_i (last_grant_q),
    .grant_idx_o  (arb_idx),
    .any_req_o    (any_req)
  );

  // The output register can take a beat when empty or draining this cycle.
  assign in_ready = !out_valid_q || axis_o_tready;
  assign accept   = (state_q == ST_PASS) && in_ready && axis_i_tvalid[grant_idx_q];

  always_comb begin
    axis_i_tready = '0;
    if (state_q == ST_PASS) axis_i_tready[grant_idx_q] = in_ready;
  end

  always_ff @(posedge clk) begin
    if (sreset) begin
      state_q        <= ST_IDLE;
      grant_idx_q    <= '0;
      last_grant_q   <= IDX_W'(NUM_INPUTS - 1);
      grant_active_q <= 1'b0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_user_q     <= '0;
      out_last_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            grant_idx_q    <= arb_idx;
            state_q        <= ST_PASS;
            grant_active_q <= 1'b1;
          end
        end
        ST_PASS: begin
          if (accept && axis_i_tlast[grant_idx_q]) begin
            last_grant_q   <= grant_idx_q;
            state_q        <= ST_IDLE;
            grant_active_q <= 1'b0;
          end
        end
        default: begin
          state_q        <= ST_IDLE;
          grant_active_q <= 1'b0;
        end
      endcase

      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= axis_i_tdata[grant_idx_q];
        out_user_q  <= axis_i_tuser[grant_idx_q];
        out_last_q  <= axis_i_tlast[grant_idx_q];
      end else if (axis_o_tready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign axis_o_tvalid = out_valid_q;
  assign axis_o_tdata  = out_data_q;
  assign axis_o_tuser  = out_user_q;
  assign axis_o_tlast  = out_last_q;
  assign grant_active  = grant_active_q;
  assign grant_idx     = grant_idx_q;

endmodule

// File: tb/tb_axis_arb_mux.sv
// tb/tb_axis_arb_mux.sv - self-checking bench for axis_arb_mux
module tb_axis_arb_mux;

  logic        clk = 1'b0;
  logic        sreset = 1'b1;
  logic [3:0]  vld = '0;
  logic [3:0]  lst = '0;
  logic [3:0]  usr = '0;
  logic [31:0] dat = '0;
  logic        ordy = 1'b1;

  logic [7:0]  i_tdata [4];
  logic [0:0]  i_tuser [4];
  logic [3:0]  i_tready;
  logic        o_tvalid;
  logic [7:0]  o_tdata;
  logic [0:0]  o_tuser;
  logic        o_tlast;
  logic        g_active;
  logic [1:0]  g_idx;

  int n_tests = 0;
  int n_fail  = 0;
  logic       mon_en = 1'b0;
  logic [9:0] got [$];

  always #5 clk = ~clk;

  always_comb begin
    for (int s = 0; s < 4; s++) begin
      i_tdata[s] = dat[8*s +: 8];
      i_tuser[s] = usr[s];
    end
  end

  axis_arb_mux #(
    .NUM_INPUTS     (4),
    .AXIS_BYTES     (1),
    .AXIS_USER_BITS (1)
  ) dut (
    .clk           (clk),
    .sreset        (sreset),
    .axis_i_tvalid (vld),
    .axis_i_tready (i_tready),
    .axis_i_tdata  (i_tdata),
    .axis_i_tuser  (i_tuser),
    .axis_i_tlast  (lst),
    .axis_o_tvalid (o_tvalid),
    .axis_o_tready (ordy),
    .axis_o_tdata  (o_tdata),
    .axis_o_tuser  (o_tuser),
    .axis_o_tlast  (o_tlast),
    .grant_active  (g_active),
    .grant_idx     (g_idx)
  );

  // Inputs only change just after a rising edge, so mid-cycle values are what the next edge sees.
  always @(negedge clk) begin
    if (mon_en && !sreset && o_tvalid && ordy) got.push_back({o_tuser, o_tlast, o_tdata});
  end

  typedef struct {
    logic [3:0]  vld;
    logic [3:0]  lst;
    logic [3:0]  usr;
    logic [31:0] dat;
    logic        ordy;
    logic [3:0]  e_rdy;
    logic        e_ov;
    logic [7:0]  e_od;
    logic        e_ou;
    logic        e_ol;
    logic        e_ga;
    logic [1:0]  e_gi;
  } vec_t;

  vec_t vt [24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sreset = 1'b1;
    vld = '0;
    lst = '0;
    dat = '0;
    ordy = 1'b1;
    repeat (2) step();
    sreset = 1'b0;
  endtask

  function automatic logic [9:0] src_beat(input int s, input int p, input int b);
    int len;
    logic [7:0] d;
    len = 1 + ((s + p) % 4);
    d = {s[1:0], p[2:0], b[2:0]};
    return {p[0] ^ b[0], (b == len - 1), d};
  endfunction

  initial begin
    logic [3:0] U;
    logic [3:0] acc;
    int pk [4];
    int bt [4];
    int sent;
    int cur;
    int nb;
    int ep [4];
    logic [9:0] exp_b;

    U = 4'b1010;
    vt[0]  = '{4'b0101, 4'b0000, U, 32'h00200010, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd0};
    vt[1]  = '{4'b0101, 4'b0000, U, 32'h00200010, 1'b1, 4'b0001, 1'b1, 8'h10, 1'b0, 1'b0, 1'b1, 2'd0};
    vt[2]  = '{4'b0101, 4'b0000, U, 32'h00200011, 1'b1, 4'b0001, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 2'd0};
    vt[3]  = '{4'b0101, 4'b0001, U, 32'h00200012, 1'b1, 4'b0001, 1'b1, 8'h12, 1'b0, 1'b1, 1'b0, 2'd0};
    vt[4]  = '{4'b0100, 4'b0000, U, 32'h00200000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd2};
    vt[5]  = '{4'b0100, 4'b0000, U, 32'h00200000, 1'b1, 4'b0100, 1'b1, 8'h20, 1'b0, 1'b0, 1'b1, 2'd2};
    vt[6]  = '{4'b0100, 4'b0000, U, 32'h00210000, 1'b1, 4'b0100, 1'b1, 8'h21, 1'b0, 1'b0, 1'b1, 2'd2};
    vt[7]  = '{4'b0100, 4'b0100, U, 32'h00220000, 1'b1, 4'b0100, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 2'd2};
    vt[8]  = '{4'b0000, 4'b0000, U, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd2};
    vt[9]  = '{4'b0010, 4'b0000, U, 32'h00003000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd1};
    vt[10] = '{4'b0010, 4'b0000, U, 32'h00003000, 1'b1, 4'b0010, 1'b1, 8'h30, 1'b1, 1'b0, 1'b1, 2'd1};
    for (int i = 11; i < 15; i++)
      vt[i] = '{4'b0010, 4'b0000, U, 32'h00003100, 1'b0, 4'b0000, 1'b1, 8'h30, 1'b1, 1'b0, 1'b1, 2'd1};
    vt[15] = '{4'b0010, 4'b0000, U, 32'h00003100, 1'b1, 4'b0010, 1'b1, 8'h31, 1'b1, 1'b0, 1'b1, 2'd1};
    vt[16] = '{4'b0010, 4'b0000, U, 32'h00003200, 1'b1, 4'b0010, 1'b1, 8'h32, 1'b1, 1'b0, 1'b1, 2'd1};
    vt[17] = '{4'b0010, 4'b0010, U, 32'h00003300, 1'b1, 4'b0010, 1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 2'd1};
    vt[18] = '{4'b0000, 4'b0000, U, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1};
    vt[19] = '{4'b1001, 4'b1001, U, 32'h40000050, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd3};
    vt[20] = '{4'b1001, 4'b1001, U, 32'h40000050, 1'b1, 4'b1000, 1'b1, 8'h40, 1'b1, 1'b1, 1'b0, 2'd3};
    vt[21] = '{4'b0001, 4'b0001, U, 32'h00000050, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd0};
    vt[22] = '{4'b0001, 4'b0001, U, 32'h00000050, 1'b1, 4'b0001, 1'b1, 8'h50, 1'b0, 1'b1, 1'b0, 2'd0};
    vt[23] = '{4'b0000, 4'b0000, U, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0};

    // Reset values
    do_reset();
    check("rst tvalid", o_tvalid, 0);
    check("rst tdata", o_tdata, 0);
    check("rst tuser", o_tuser, 0);
    check("rst tlast", o_tlast, 0);
    check("rst grant_active", g_active, 0);
    check("rst grant_idx", g_idx, 0);
    check("rst i_tready", i_tready, 0);

    // Directed cycle table: two packets, output stall, wrap-around grant
    foreach (vt[i]) begin
      vld  = vt[i].vld;
      lst  = vt[i].lst;
      usr  = vt[i].usr;
      dat  = vt[i].dat;
      ordy = vt[i].ordy;
      @(negedge clk);
      check($sformatf("v%0d i_tready", i), i_tready, vt[i].e_rdy);
      step();
      check($sformatf("v%0d tvalid", i), o_tvalid, vt[i].e_ov);
      if (vt[i].e_ov) begin
        check($sformatf("v%0d tdata", i), o_tdata, vt[i].e_od);
        check($sformatf("v%0d tuser", i), o_tuser, vt[i].e_ou);
        check($sformatf("v%0d tlast", i), o_tlast, vt[i].e_ol);
      end
      check($sformatf("v%0d grant_active", i), g_active, vt[i].e_ga);
      check($sformatf("v%0d grant_idx", i), g_idx, vt[i].e_gi);
    end

    // Round robin with all sources offering 1-beat packets
    do_reset();
    got.delete();
    mon_en = 1'b1;
    vld = 4'b1111;
    lst = 4'b1111;
    usr = U;
    dat = 32'h03020100;
    repeat (30) step();
    vld = '0;
    repeat (3) step();
    check("rr beat count ok", (got.size() >= 12), 1);
    for (int k = 0; k < 12 && k < got.size(); k++)
      check($sformatf("rr beat %0d", k), got[k][7:0], k % 4);

    // Granted source 1 drops tvalid mid-packet while source 3 waits
    do_reset();
    got.delete();
    vld = 4'b1010;
    lst = 4'b1000;
    dat = 32'hD00000A0 | 32'h0000A000;
    dat = 32'hD000A000;
    step();
    step();
    vld = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("stall%0d tready3", c), i_tready[3], 0);
      check($sformatf("stall%0d grant_idx", c), g_idx, 1);
      step();
    end
    vld = 4'b1010;
    dat = 32'hD000A100;
    check("stall resume tready3", i_tready[3], 0);
    step();
    lst = 4'b1010;
    dat = 32'hD000A200;
    step();
    vld = 4'b1000;
    lst = 4'b1000;
    repeat (2) step();
    vld = '0;
    repeat (2) step();
    check("stall beat count", got.size(), 4);
    if (got.size() == 4) begin
      check("stall beat0", got[0][7:0], 8'hA0);
      check("stall beat1", got[1][7:0], 8'hA1);
      check("stall beat2", got[2][7:0], 8'hA2);
      check("stall beat3", got[3][7:0], 8'hD0);
    end

    // sreset during beat 2 of a 4-beat packet from source 2
    do_reset();
    vld = 4'b0100;
    lst = 4'b0000;
    dat = 32'h00600000;
    step();
    step();
    dat = 32'h00610000;
    sreset = 1'b1;
    step();
    check("srst tvalid", o_tvalid, 0);
    check("srst grant_active", g_active, 0);
    check("srst grant_idx", g_idx, 0);
    check("srst i_tready", i_tready, 0);
    sreset = 1'b0;
    vld = 4'b0101;
    lst = 4'b0001;
    dat = 32'h00620070;
    step();
    check("post-srst grant_active", g_active, 1);
    check("post-srst grant_idx", g_idx, 0);
    step();
    check("post-srst tvalid", o_tvalid, 1);
    check("post-srst tdata", o_tdata, 8'h70);
    vld = '0;
    repeat (3) step();

    // Random valid/ready back-pressure against a per-source packet scoreboard
    do_reset();
    got.delete();
    for (int s = 0; s < 4; s++) begin
      pk[s] = 0;
      bt[s] = 0;
      ep[s] = 0;
    end
    sent = 0;
    for (int cyc = 0; cyc < 60000 && sent < 10000; cyc++) begin
      for (int s = 0; s < 4; s++) begin
        if (!vld[s] && ($urandom % 4 != 0)) begin
          exp_b = src_beat(s, pk[s], bt[s]);
          vld[s] = 1'b1;
          dat[8*s +: 8] = exp_b[7:0];
          lst[s] = exp_b[8];
          usr[s] = exp_b[9];
        end
      end
      ordy = ($urandom % 4 != 0);
      @(negedge clk);
      acc = vld & i_tready;
      step();
      for (int s = 0; s < 4; s++) begin
        if (acc[s]) begin
          sent++;
          vld[s] = 1'b0;
          if (lst[s]) begin
            bt[s] = 0;
            pk[s]++;
          end else begin
            bt[s]++;
          end
        end
      end
    end
    vld = '0;
    ordy = 1'b1;
    repeat (4) step();
    mon_en = 1'b0;
    check("sb beats sent", (sent >= 10000), 1);
    check("sb beats received", got.size(), sent);
    cur = -1;
    nb = 0;
    foreach (got[k]) begin
      if (cur < 0) begin
        cur = int'(got[k][7:6]);
        nb = 0;
      end
      exp_b = src_beat(cur, ep[cur], nb);
      check($sformatf("sb beat %0d", k), got[k], exp_b);
      if (exp_b[8]) begin
        ep[cur]++;
        cur = -1;
      end else begin
        nb++;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
